// File: rtl/req_arb4.sv
// req_arb4: 4-requester arbiter with hold limit, fixed-priority or round-robin selection
module req_arb4 #(
   parameter int MAX_HOLD = 8,
   parameter bit RR_EN    = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       done,
   input  logic       mode,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_vld,
   output logic       timeout
);
   localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
   state_t        state_q, state_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [1:0]    gnt_id_q, gnt_id_d;
   logic          timeout_q, timeout_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]    last_id_q, last_id_d;
   logic [1:0]    win_id, idx;
   logic          win_vld, rel;
   // winner selection: round-robin searches upward from the last owner, fixed picks the highest set bit
   always_comb begin
      win_id  = 2'd0;
      win_vld = 1'b0;
      idx     = 2'd0;
      if (RR_EN && mode) begin
         for (int i = 1; i <= 4; i++) begin
            idx = last_id_q + 2'(i);
            if (!win_vld && req[idx]) begin
               win_id  = idx;
               win_vld = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
               win_id  = 2'(i);
               win_vld = 1'b1;
            end
         end
      end
   end
   // next state: hold or release the grant in BUSY, arbitrate in IDLE and GAP
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      gnt_id_d   = gnt_id_q;
      timeout_d  = 1'b0;
      hold_cnt_d = hold_cnt_q;
      last_id_d  = last_id_q;
      rel        = done || !req[gnt_id_q] || (hold_cnt_q == HOLD_LAST);
      if (state_q == BUSY) begin
         if (rel) begin
            state_d    = GAP;
            gnt_d      = 4'b0000;
            gnt_id_d   = 2'd0;
            hold_cnt_d = '0;
            last_id_d  = gnt_id_q;
            timeout_d  = !done && req[gnt_id_q];
         end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
         end
      end else begin
         state_d    = win_vld ? BUSY : IDLE;
         gnt_d      = win_vld ? (4'b0001 << win_id) : 4'b0000;
         gnt_id_d   = win_id;
         hold_cnt_d = '0;
      end
   end
   // state and registered outputs; reset drops any grant immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_q      <= 4'b0000;
         gnt_id_q   <= 2'd0;
         timeout_q  <= 1'b0;
         hold_cnt_q <= '0;
         last_id_q  <= 2'b11;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gnt_id_q   <= gnt_id_d;
         timeout_q  <= timeout_d;
         hold_cnt_q <= hold_cnt_d;
         last_id_q  <= last_id_d;
      end
   end
   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign gnt_vld = |gnt_q;
   assign timeout = timeout_q;
endmodule

// File: tb/tb_req_arb4.sv
// tb_req_arb4: directed and randomized checks of req_arb4 against a behavioural model
module tb_req_arb4;
   localparam int MH = 8;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic       done = 1'b0, mode = 1'b0;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_vld, timeout;
   int checks = 0, failures = 0;
   int owner = -1, held = 0, last = 3;
   bit to = 1'b0;

   req_arb4 #(.MAX_HOLD(MH), .RR_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done), .mode(mode),
      .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic int pick(logic [3:0] r, bit rr, int l);
      if (rr) begin
         for (int k = 1; k <= 4; k++) if (r[(l + k) % 4]) return (l + k) % 4;
         return -1;
      end
      for (int i = 3; i >= 0; i--) if (r[i]) return i;
      return -1;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [7:0] e;
      if (owner >= 0) begin
         if (done || !req[owner]) begin last = owner; owner = -1; to = 1'b0; end
         else if (held == MH) begin last = owner; owner = -1; to = 1'b1; end
         else held++;
      end else begin
         owner = pick(req, mode, last);
         held  = 1;
         to    = 1'b0;
      end
      @(posedge clk);
      #1;
      e = (owner >= 0) ? {4'(1 << owner), 2'(owner), 1'b1, to} : {6'b0, 1'b0, to};
      check("cycle{gnt,id,vld,to}", {24'b0, gnt, gnt_id, gnt_vld, timeout}, {24'b0, e});
   endtask

   initial begin
      #12;
      check("reset_outputs", {gnt, gnt_id, gnt_vld, timeout}, 8'h00);
      rst_n = 1'b1;
      // single requester held until timeout, then re-granted after the gap
      req = 4'b0100;
      tick();
      check("t1_gnt", gnt, 4'b0100);
      check("t1_id", gnt_id, 2);
      repeat (7) tick();
      check("t1_still_held", gnt, 4'b0100);
      tick();
      check("t1_timeout", timeout, 1);
      check("t1_gap", gnt, 0);
      tick();
      check("t1_regrant", gnt_id, 2);
      check("t1_to_pulse", timeout, 0);
      req = 4'b0000;
      tick(); tick();
      // fixed priority always favours id 3
      mode = 1'b0;
      req  = 4'b1011;
      repeat (30) begin
         done = (owner >= 0 && held == 3);
         tick();
         if (gnt_vld) check("t2_id3", gnt_id, 3);
      end
      done = 1'b0;
      req  = 4'b0000;
      tick(); tick();
      // asynchronous reset in the middle of a grant
      req  = 4'b1111;
      mode = 1'b1;
      tick(); tick(); tick();
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_async_gnt", gnt, 0);
      check("t6_async_id", gnt_id, 0);
      check("t6_async_vld", gnt_vld, 0);
      owner = -1; last = 3; to = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("t6_first_rr", gnt_id, 0);
      // round-robin rotation with done on the second busy cycle
      repeat (20) begin
         done = (owner >= 0 && held == 2);
         tick();
      end
      done = 1'b0;
      req  = 4'b0000;
      tick(); tick();
      // requester 1 withdraws on its fourth busy cycle
      req = 4'b0010;
      tick();
      check("t4_gnt1", gnt, 4'b0010);
      tick(); tick(); tick();
      req = 4'b0000;
      tick();
      check("t4_released", gnt, 0);
      check("t4_no_to", timeout, 0);
      req = 4'b0011;
      tick();
      check("t4_rr_after1", gnt_id, 0);
      req = 4'b0000;
      tick(); tick();
      // done coinciding with the hold limit is a normal release
      mode = 1'b0;
      req  = 4'b1000;
      repeat (8) tick();
      done = 1'b1;
      tick();
      check("t5_released", gnt, 0);
      check("t5_no_to", timeout, 0);
      done = 1'b0;
      req  = 4'b0000;
      tick(); tick();
      // randomized traffic
      repeat (500) begin
         if ($urandom_range(0, 7) == 0) req = 4'($urandom);
         if ($urandom_range(0, 3) == 0) mode = 1'($urandom);
         done = ($urandom_range(0, 5) == 0);
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
